// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined LEGv8 CPU.
//   NOP_INSTR   : encoding inserted into the pipeline as a bubble
//   INSTR_W     : instruction word width
//   ADDR_W      : address / PC width
//   if_state_t  : fetch-stage FSM states
//   if_id_t     : IF/ID pipeline register contents
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {
    S_START    = 2'd0,
    S_RUN      = 2'd1,
    S_STALL    = 2'd2,
    S_REDIRECT = 2'd3
  } if_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               valid;
  } if_id_t;

  // Contents of IF/ID when it carries no instruction.
  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus between the fetch stage and its neighbours (instruction memory,
// hazard unit, branch resolution, decode stage).
//   imem_addr     : instruction-memory address (PC register)
//   imem_data     : instruction word for imem_addr, same cycle
//   stall         : hold PC and IF/ID
//   flush         : branch taken, redirect to branch_target
//   branch_target : redirect PC, sampled with flush
//   id_instr / id_pc / id_pc_plus4 / id_valid : IF/ID register outputs
// Modports: master = fetch stage, slave = its environment.
interface if_stage_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic [ADDR_W-1:0]  id_pc_plus4;
  logic               id_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  flush,
    input  branch_target,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output flush,
    output branch_target,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  id_valid
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset_n : clock, asynchronous active-low reset (resets to a bubble)
//   load         : capture d
//   bubble       : capture a bubble (takes priority over load)
//   d / q        : register input / output
// With neither load nor bubble the register holds.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= IF_ID_BUBBLE;
    end else if (bubble) begin
      q <= IF_ID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and fills the IF/ID register for decode.
//   Parameters : RESET_PC (PC after reset), START_DELAY (1..15 idle cycles
//                after reset release before the first fetch)
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   bus        : if_stage_if.master (memory, hazard, branch and ID signals)
//   perf_fetched / perf_bubbles : only when IF_PERF_COUNT_EN is defined;
//                counts of edges loading a valid instruction / a bubble
//                (bubbles during start-up excluded). Both hold on stall.
// Optional feature macro: IF_PERF_COUNT_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       START_DELAY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  if_stage_if.master      bus
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  localparam logic [3:0] START_LAST = 4'(START_DELAY - 1);

  if_state_t         state, state_next;
  logic [3:0]        start_cnt, start_cnt_next;
  logic [ADDR_W-1:0] pc, pc_next, pc_plus4;
  logic              id_load, id_bubble;
  if_id_t            id_d, id_q;

  assign pc_plus4 = pc + 64'd4;

  // RUN, STALL and REDIRECT share one set of rules (flush > stall > advance);
  // the state only records what happened on the last edge.
  always_comb begin
    state_next     = state;
    start_cnt_next = start_cnt;
    pc_next        = pc;
    id_load        = 1'b0;
    id_bubble      = 1'b0;
    unique case (state)
      S_START: begin
        id_bubble = 1'b1;
        if (start_cnt == START_LAST) begin
          state_next = S_RUN;
        end else begin
          start_cnt_next = start_cnt + 4'd1;
        end
      end
      S_RUN, S_STALL, S_REDIRECT: begin
        if (bus.flush) begin
          pc_next    = align_word(bus.branch_target);
          id_bubble  = 1'b1;
          state_next = S_REDIRECT;
        end else if (bus.stall) begin
          state_next = S_STALL;
        end else begin
          pc_next    = pc_plus4;
          id_load    = 1'b1;
          state_next = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_START;
      start_cnt <= '0;
      pc        <= RESET_PC;
    end else begin
      state     <= state_next;
      start_cnt <= start_cnt_next;
      pc        <= pc_next;
    end
  end

  assign id_d = '{
    instr:    bus.imem_data,
    pc:       pc,
    pc_plus4: pc_plus4,
    valid:    1'b1
  };

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (id_load),
    .bubble  (id_bubble),
    .d       (id_d),
    .q       (id_q)
  );

  assign bus.imem_addr   = pc;
  assign bus.id_instr    = id_q.instr;
  assign bus.id_pc       = id_q.pc;
  assign bus.id_pc_plus4 = id_q.pc_plus4;
  assign bus.id_valid    = id_q.valid;

`ifdef IF_PERF_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (id_load) begin
      perf_fetched <= perf_fetched + 32'd1;
    end else if (id_bubble && (state != S_START)) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
